i2c_fnv_target: RTL



---
 rtl/i2c_fnv_target.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_fnv_target.sv
// I2C target that folds every received write byte into an FNV-1a hash and returns the hash on reads.
// SCL/SDA are oversampled on clk; the hash updates one clk after the synchronised 8th SCL rise.
module i2c_fnv_target #(
  parameter logic [6:0] I2C_ADDR    = 7'h2A,
  parameter int         HASH_WIDTH  = 32,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic                  busy,
  output logic [HASH_WIDTH-1:0] hash_out,
  output logic                  hash_update,
  output logic [15:0]           byte_count
);

  localparam logic [63:0] BASIS_64 = (HASH_WIDTH == 64) ? 64'hCBF2_9CE4_8422_2325
                                                        : 64'h0000_0000_811C_9DC5;
  localparam logic [63:0] PRIME_64 = (HASH_WIDTH == 64) ? 64'h0000_0100_0000_01B3
                                                        : 64'h0000_0000_0100_0193;
  localparam logic [HASH_WIDTH-1:0] BASIS = BASIS_64[HASH_WIDTH-1:0];
  localparam logic [HASH_WIDTH-1:0] PRIME = PRIME_64[HASH_WIDTH-1:0];

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_CMD    = 3'd2;
  localparam logic [2:0] S_WDATA  = 3'd3;
  localparam logic [2:0] S_RDATA  = 3'd4;
  localparam logic [2:0] S_IGNORE = 3'd5;

  // Constant-prime multiply as a sum of shifted copies, one per set prime bit
  function automatic logic [HASH_WIDTH-1:0] fnv_step(input logic [HASH_WIDTH-1:0] h,
                                                      input logic [7:0] b);
    logic [HASH_WIDTH-1:0] x;
    logic [HASH_WIDTH-1:0] acc;
    x   = h ^ {{(HASH_WIDTH-8){1'b0}}, b};
    acc = '0;
    for (int i = 0; i < HASH_WIDTH; i++) begin
      if (PRIME[i]) acc = acc + (x << i);
    end
    return acc;
  endfunction

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  logic [2:0]            state_q, state_d, nxt_q, nxt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            rx_q, rx_d;
  logic [HASH_WIDTH-1:0] tx_q, tx_d, hash_q, hash_d, hash_next;
  logic                  ack_q, ack_d, mack_q, mack_d;
  logic                  sda_oe_q, sda_oe_d, busy_q, busy_d, hash_upd_q, hash_upd_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [7:0]            byte_in;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & ~sda_s & sda_hist_q;
  assign stop_det  = scl_s & scl_hist_q & sda_s & ~sda_hist_q;
  assign byte_in   = {rx_q, sda_s};
  assign hash_next = fnv_step(hash_q, byte_in);
  assign hash_upd_d = (hash_d != hash_q);

  always_comb begin
    state_d   = state_q;
    nxt_d     = nxt_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    ack_d     = ack_q;
    mack_d    = mack_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    hash_d    = hash_q;
    cnt_d     = cnt_q;
    if (stop_det) begin
      state_d   = S_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_ADDR, S_CMD, S_WDATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            rx_d      = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              ack_d = 1'b1;
              nxt_d = S_WDATA;
              if (state_q == S_ADDR) begin
                // General call (0x00) is never claimed
                if (byte_in[7:1] == I2C_ADDR && I2C_ADDR != 7'h00) begin
                  busy_d = 1'b1;
                  nxt_d  = byte_in[0] ? S_RDATA : S_CMD;
                  tx_d   = hash_q;
                end else begin
                  ack_d = 1'b0;
                  nxt_d = S_IGNORE;
                end
              end else if (state_q == S_CMD) begin
                if (byte_in == 8'h01) begin
                  hash_d = BASIS;
                  cnt_d  = 16'd0;
                end else if (byte_in != 8'h02) begin
                  ack_d = 1'b0;
                  nxt_d = S_IGNORE;
                end
              end else begin
                hash_d = hash_next;
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
              end
            end
          end else if (scl_rise && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd9;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = ack_q;
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            bit_cnt_d = 4'd0;
            state_d   = nxt_q;
            sda_oe_d  = 1'b0;
            if (nxt_q == S_IGNORE) busy_d = 1'b0;
            if (nxt_q == S_RDATA) begin
              sda_oe_d = ~tx_q[HASH_WIDTH-1];
              tx_d     = {tx_q[HASH_WIDTH-2:0], 1'b1};
            end
          end
        end
        S_RDATA: begin
          // Ones shift in behind the snapshot, so reads past the hash return 0xFF
          if (scl_rise && bit_cnt_q < 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_rise && bit_cnt_q == 4'd8) begin
            mack_d    = ~sda_s;
            bit_cnt_d = 4'd9;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
          end else if (scl_fall && bit_cnt_q == 4'd9 && !mack_q) begin
            state_d  = S_IGNORE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            sda_oe_d = ~tx_q[HASH_WIDTH-1];
            tx_d     = {tx_q[HASH_WIDTH-2:0], 1'b1};
            if (bit_cnt_q == 4'd9) bit_cnt_d = 4'd0;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= S_IDLE;
      nxt_q      <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      rx_q       <= '0;
      tx_q       <= '0;
      ack_q      <= 1'b0;
      mack_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      hash_q     <= BASIS;
      hash_upd_q <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
      state_q    <= state_d;
      nxt_q      <= nxt_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      ack_q      <= ack_d;
      mack_q     <= mack_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      hash_q     <= hash_d;
      hash_upd_q <= hash_upd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign busy        = busy_q;
  assign hash_out    = hash_q;
  assign hash_update = hash_upd_q;
  assign byte_count  = cnt_q;

endmodule
